// File: rtl/hub75_pkg.sv
// Shared types and default geometry for the HUB75 pixel writer.
package hub75_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } wr_state_e;

  localparam int HUB75_HPIXEL = 64;
  localparam int HUB75_VPIXEL = 64;
  localparam int HUB75_BPP    = 8;

endpackage

// File: rtl/hub75_pixel_writer_if.sv
// Pixel stream handshake between a raster source (master) and the writer (slave).
interface hub75_pixel_writer_if
  import hub75_pkg::*;
#(
  parameter int bpp_p = HUB75_BPP
) ();

  logic [3*bpp_p-1:0] i_px_data;
  logic               i_px_valid;
  logic               i_px_sof;
  logic               i_px_eol;
  logic               o_px_ready;

  modport master (
    output i_px_data, i_px_valid, i_px_sof, i_px_eol,
    input  o_px_ready
  );

  modport slave (
    input  i_px_data, i_px_valid, i_px_sof, i_px_eol,
    output o_px_ready
  );

endinterface

// File: rtl/hub75_gamma_lut.sv
// Synchronous gamma-2.2 ROM for one colour channel; table is built at elaboration.
module hub75_gamma_lut #(
  parameter int bpp_p = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [bpp_p-1:0] addr_i,
  output logic [bpp_p-1:0] data_o
);

  localparam int depth_lp = 2 ** bpp_p;

  function automatic logic [bpp_p-1:0] gamma_fn(input int x);
    real max_r;
    real r;
    max_r = real'(depth_lp - 1);
    r     = ((real'(x) / max_r) ** 2.2) * max_r + 0.5;
    return bpp_p'($rtoi(r));
  endfunction

  logic [bpp_p-1:0] rom [depth_lp];

  for (genvar i = 0; i < depth_lp; i++) begin : g_rom
    assign rom[i] = gamma_fn(i);
  end

  // registered ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_o <= '0;
    else        data_o <= rom[addr_i];
  end

endmodule

// File: rtl/hub75_pixel_writer.sv
// Stream-to-framebuffer loader for the HUB75 driver.
// Optional feature macro: HUB75_PIXEL_GAMMA_EN (per-channel gamma LUT, latency 2).
//
//   state    | meaning
//   WAIT_SOF | idle between frames, beats without sof discarded
//   ACTIVE   | inside a frame, each beat checked against the column count
//   DROP     | framing error seen, beats discarded until the next sof
module hub75_pixel_writer
  import hub75_pkg::*;
#(
  parameter int  hpixel_p     = HUB75_HPIXEL,
  parameter int  vpixel_p     = HUB75_VPIXEL,
  parameter int  bpp_p        = HUB75_BPP,
  localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hub75_pixel_writer_if.slave     px,
  output logic [addr_width_p-1:0] o_framebuf_wr_addr,
  output logic [3*bpp_p-1:0]      o_framebuf_wr_data,
  output logic                    o_framebuf_wr_en,
  output logic                    o_frame_done,
  output logic                    o_err_sync,
  input  logic                    i_err_clr
);

  localparam int col_width_lp = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int row_width_lp = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
  localparam logic [col_width_lp-1:0] col_last_lp = col_width_lp'(hpixel_p - 1);
  localparam logic [row_width_lp-1:0] row_last_lp = row_width_lp'(vpixel_p - 1);

  wr_state_e               state_q;
  logic [col_width_lp-1:0] col_q;
  logic [row_width_lp-1:0] row_q;
  // writes are row-major and contiguous, so a running counter equals row*hpixel_p+col
  logic [addr_width_p-1:0] pix_addr_q;
  logic                    ready_q;
  logic                    wr_en_q;
  logic                    done_q;
  logic                    err_q;
  logic                    err_d;
  logic [addr_width_p-1:0] wr_addr_q;
  logic [3*bpp_p-1:0]      wr_data_q;
  logic                    beat;
  logic                    at_eol_col;
  logic                    at_last_row;
  logic                    frame_err;

  assign px.o_px_ready = ready_q;
  assign beat          = px.i_px_valid & ready_q;
  assign at_eol_col    = (col_q == col_last_lp);
  assign at_last_row   = (row_q == row_last_lp);

  // inside a frame, a repeated sof or an eol that disagrees with the column is an error
  always_comb begin
    frame_err = beat & (state_q == ACTIVE) & (px.i_px_sof | (px.i_px_eol != at_eol_col));
    err_d     = frame_err | (err_q & ~i_err_clr);
  end

  // writer FSM, position counters and first output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_SOF;
      col_q      <= '0;
      row_q      <= '0;
      pix_addr_q <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= err_d;
      if (beat) begin
        if (px.i_px_sof) begin
          // any sof starts a fresh frame at address 0, whatever the state
          wr_en_q    <= 1'b1;
          wr_addr_q  <= '0;
          wr_data_q  <= px.i_px_data;
          col_q      <= col_width_lp'(1);
          row_q      <= '0;
          pix_addr_q <= addr_width_p'(1);
          state_q    <= ACTIVE;
        end else if (state_q == ACTIVE) begin
          if (px.i_px_eol != at_eol_col) begin
            state_q <= DROP;
          end else begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= pix_addr_q;
            wr_data_q  <= px.i_px_data;
            pix_addr_q <= pix_addr_q + 1'b1;
            if (at_eol_col) begin
              col_q <= '0;
              if (at_last_row) begin
                done_q  <= 1'b1;
                row_q   <= '0;
                state_q <= WAIT_SOF;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_err_sync = err_q;

`ifdef HUB75_PIXEL_GAMMA_EN
  logic [addr_width_p-1:0] addr_dly_q;
  logic                    en_dly_q;
  logic                    done_dly_q;

  for (genvar ch = 0; ch < 3; ch++) begin : g_gamma
    hub75_gamma_lut #(.bpp_p(bpp_p)) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .addr_i (wr_data_q[ch*bpp_p +: bpp_p]),
      .data_o (o_framebuf_wr_data[ch*bpp_p +: bpp_p])
    );
  end

  // delay the control side by the LUT's register so it stays aligned with data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_dly_q <= '0;
      en_dly_q   <= 1'b0;
      done_dly_q <= 1'b0;
    end else begin
      addr_dly_q <= wr_addr_q;
      en_dly_q   <= wr_en_q;
      done_dly_q <= done_q;
    end
  end

  assign o_framebuf_wr_addr = addr_dly_q;
  assign o_framebuf_wr_en   = en_dly_q;
  assign o_frame_done       = done_dly_q;
`else
  assign o_framebuf_wr_addr = wr_addr_q;
  assign o_framebuf_wr_data = wr_data_q;
  assign o_framebuf_wr_en   = wr_en_q;
  assign o_frame_done       = done_q;
`endif

endmodule
